// File: rtl/sampswitch_driver.sv
// Timing controller for the analog sampling switch: track window, guard gap,
// then a conversion hold window with a one-cycle conv_start pulse.
module sampswitch_driver #(
  parameter int CNT_W  = 8,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_samp_len,
  input  logic [CNT_W-1:0]  cfg_guard_len,
  input  logic [CNT_W-1:0]  cfg_hold_len,
  output logic              samp_clk,
  output logic              samp_clk_b,
  output logic              conv_start,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_GUARD  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   guard_len_q, guard_len_d;
  logic [CNT_W-1:0]   hold_len_q, hold_len_d;
  logic               cont_q, cont_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic               samp_clk_q, samp_clk_b_q;
  logic               conv_start_q, conv_start_d;
  logic               busy_q;
  logic               done_q, done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    guard_len_d  = guard_len_q;
    hold_len_d   = hold_len_q;
    cont_d       = cont_q;
    frame_cnt_d  = frame_cnt_q;
    conv_start_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_SAMPLE;
          cnt_d       = cfg_samp_len;
          guard_len_d = cfg_guard_len;
          hold_len_d  = cfg_hold_len;
          cont_d      = continuous;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (guard_len_q != '0) begin
          state_d = ST_GUARD;
          cnt_d   = guard_len_q - CNT_W'(1);
        end else begin
          state_d      = ST_HOLD;
          cnt_d        = hold_len_q;
          conv_start_d = 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = ST_HOLD;
          cnt_d        = hold_len_q;
          conv_start_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          // Back-to-back frames re-latch config with no idle gap.
          if (cont_q && !stop) begin
            state_d     = ST_SAMPLE;
            cnt_d       = cfg_samp_len;
            guard_len_d = cfg_guard_len;
            hold_len_d  = cfg_hold_len;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything and discards the in-flight frame.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      cnt_d        = cnt_q;
      guard_len_d  = guard_len_q;
      hold_len_d   = hold_len_q;
      cont_d       = cont_q;
      frame_cnt_d  = frame_cnt_q;
      conv_start_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      guard_len_q  <= '0;
      hold_len_q   <= '0;
      cont_q       <= 1'b0;
      frame_cnt_q  <= '0;
      samp_clk_q   <= 1'b0;
      samp_clk_b_q <= 1'b1;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      guard_len_q  <= guard_len_d;
      hold_len_q   <= hold_len_d;
      cont_q       <= cont_d;
      frame_cnt_q  <= frame_cnt_d;
      samp_clk_q   <= (state_d == ST_SAMPLE);
      samp_clk_b_q <= (state_d != ST_SAMPLE);
      conv_start_q <= conv_start_d;
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= done_d;
    end
  end

  assign samp_clk   = samp_clk_q;
  assign samp_clk_b = samp_clk_b_q;
  assign conv_start = conv_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign state_dbg  = state_q;

endmodule
